mem_test_ctrl: RTL
==================

// Module: mem_test_ctrl
// PURPOSE
//  Initiator side of the word-memory interface. It drives a 32-word pattern memory with a fixed-pattern write sweep,
//  then a read-back/verify sweep, and counts mismatches. One byte of the last word read is shown on led[7:0].
//  Sits between board switches/buttons and the memory block, replacing manual sw/mem_write toggling.
// PARAMETERS
//  ADDR_W    5   word-address width; depth = 2**ADDR_W words
//  DATA_W    32  memory word width (>= 32)
//  READ_LAT  1   memory read latency in clk cycles (>= 1), mem_re edge to valid mem_rdata
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  start      in   1         level; sampled only in IDLE/DONE, starts a test run
//  mode       in   2         pattern select, sampled with start
//  byte_sel   in   2         byte of captured word shown on led (live, not sampled)
//  mem_addr   out  ADDR_W    word address to memory
//  mem_wdata  out  DATA_W    write data
//  mem_we     out  1         write strobe, one word per cycle
//  mem_re     out  1         read strobe
//  mem_rdata  in   DATA_W    read data, valid READ_LAT cycles after mem_re
//  busy       out  1         high while WRITE/READ/WAIT/CHECK
//  done       out  1         high in DONE until next start
//  err_cnt    out  ADDR_W+1  mismatch count of last run
//  led        out  8         byte byte_sel of last captured read word
// BEHAVIOUR
//  Reset: one clock, asynchronous, active-low. State=IDLE; all outputs 0 (mem_we, mem_re, busy, done, err_cnt,
//   led, mem_addr, mem_wdata); the capture register is also 0.
//  Outputs: all registered except led, which is a registered capture word muxed by byte_sel.
//  Patterns P(mode): 00=32'h1234_5678, 01=32'h8765_4321, 10=32'hFFFF_FFFF, 11=32'h0001_1000.
//   Each pattern is zero-extended to DATA_W.
//   Word written/expected at address a: P(mode) ^ a, where a is zero-extended. This catches address aliasing.
//  FSM:
//   IDLE/DONE -> WRITE when start=1. On entry: mode latched, err_cnt cleared, addr=0, done cleared.
//   WRITE: mem_we=1 with mem_addr=addr and mem_wdata=P^addr. addr increments each cycle.
//    At addr=2**ADDR_W-1, addr wraps to 0 and the FSM goes to READ.
//   READ: mem_re=1 for one cycle with mem_addr=addr -> WAIT.
//   WAIT: mem_re=0; stays READ_LAT cycles in total -> CHECK.
//   CHECK: mem_rdata captured into the led word. If mem_rdata != P^addr, err_cnt+1.
//    If addr is last: -> DONE, done=1, busy=0. Otherwise addr+1 -> READ.
//  mem_we and mem_re are never high in the same cycle. mem_addr holds its last value when idle.
//  start held high in DONE immediately starts a new run. start while busy is ignored.
//  mode changes mid-run have no effect. byte_sel changes update led combinationally from the capture register.
//  Timing (defaults): start sampled at edge 0.
//   busy=1 from edge 1. Writes occupy edges 1..32. Reads take 3 cycles/word, edges 33..128.
//   done=1 and busy=0 from edge 129.
//  err_cnt range 0..2**ADDR_W; the width cannot overflow.
//  rst_n low mid-run: immediate abort to IDLE with outputs as at reset. No partial write strobe after assertion.
// TESTING
//  1 Reset mid-WRITE (edge 10) -> mem_we=0 asynchronously. Then IDLE: busy=0, done=0, err_cnt=0, led=0.
//  2 mode=00, ideal memory, start 1 cycle -> 32 writes (addr0 data 32'h1234_5678, addr5 32'h1234_567D).
//    Then done at edge 129 with err_cnt=0.
//  3 mode=10, memory model corrupts addr 7 bit 0 -> err_cnt=1.
//    Same run with addr bit 4 stuck-at-0 (aliasing) -> err_cnt=16.
//  4 After run 2, byte_sel 00/01/10/11 -> led = 8'h67/8'h56/8'h34/8'h12 (last word 32'h1234_5667).
//  5 Pulse start at edges 5 and 60 of a run -> ignored, single run. Hold start high through DONE -> back-to-back runs.
//  6 READ_LAT=3 build -> mem_rdata sampled exactly 3 cycles after mem_re. done at edge 1+32+32*5=193.

Source files
------------

// File: rtl/mem_test_ctrl.sv
// Memory test initiator: writes pattern^address across the whole memory, reads it back
// and counts mismatches; led shows a selected byte of the last word read.
module mem_test_ctrl #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [1:0]        byte_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_cnt,
    output logic [7:0]        led
);
    localparam int unsigned       LatW     = $clog2(READ_LAT + 1);
    localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};
    localparam logic [LatW-1:0]   LatMax   = LatW'(READ_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StWait,
        StCheck,
        StDone
    } state_e;

    state_e              state_q;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LatW-1:0]     lat_q;
    logic [DATA_W-1:0]   cap_q;

    // Pattern XOR address, so aliased addresses read back a wrong word.
    function automatic logic [DATA_W-1:0] expected(input logic [1:0] m,
                                                   input logic [ADDR_W-1:0] a);
        logic [31:0] p;
        case (m)
            2'b00:   p = 32'h1234_5678;
            2'b01:   p = 32'h8765_4321;
            2'b10:   p = 32'hFFFF_FFFF;
            default: p = 32'h0001_1000;
        endcase
        return DATA_W'(p) ^ DATA_W'(a);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mode_q    <= '0;
            addr_q    <= '0;
            lat_q     <= '0;
            cap_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StWrite;
                        mode_q    <= mode;
                        addr_q    <= '0;
                        err_cnt   <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= '0;
                        mem_wdata <= expected(mode, '0);
                    end
                end
                StWrite: begin
                    if (addr_q == LastAddr) begin
                        state_q  <= StRead;
                        addr_q   <= '0;
                        mem_we   <= 1'b0;
                        mem_re   <= 1'b1;
                        mem_addr <= '0;
                    end else begin
                        addr_q    <= addr_q + 1'b1;
                        mem_addr  <= addr_q + 1'b1;
                        mem_wdata <= expected(mode_q, addr_q + 1'b1);
                    end
                end
                StRead: begin
                    mem_re  <= 1'b0;
                    lat_q   <= LatW'(1);
                    state_q <= StWait;
                end
                StWait: begin
                    // Capture on the edge where read data is valid for exactly this cycle.
                    if (lat_q == LatMax) begin
                        cap_q   <= mem_rdata;
                        state_q <= StCheck;
                        if (mem_rdata != expected(mode_q, addr_q)) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                StCheck: begin
                    if (addr_q == LastAddr) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        addr_q   <= addr_q + 1'b1;
                        mem_addr <= addr_q + 1'b1;
                        mem_re   <= 1'b1;
                        state_q  <= StRead;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        led = 8'h00;
        case (byte_sel)
            2'b00:   led = cap_q[7:0];
            2'b01:   led = cap_q[15:8];
            2'b10:   led = cap_q[23:16];
            default: led = cap_q[31:24];
        endcase
    end

endmodule
